soc_axi_burst_splitter: RTL and testbench

//  AXI4 slave-to-master shim sitting directly upstream of the SoC register adapter.

---
 rtl/soc_axi_burst_splitter.sv | 230 +++++++++++++++++++++++
 tb/tb_soc_axi_burst_splitter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_axi_burst_splitter.sv
// AXI4 burst-to-single-beat shim in front of the SoC register adapter: one outstanding access, AW+W issued together.
// Optional downstream response timeout is compiled in with `define SOC_BURST_TIMEOUT_EN.
module soc_axi_burst_splitter #(
  parameter int TAGW        = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            s_arvalid,
  output logic            s_arready,
  input  logic [31:0]     s_araddr,
  input  logic [TAGW-1:0] s_arid,
  input  logic [7:0]      s_arlen,
  input  logic [1:0]      s_arburst,
  input  logic [2:0]      s_arsize,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [31:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic [TAGW-1:0] s_rid,
  output logic            s_rlast,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [31:0]     s_awaddr,
  input  logic [TAGW-1:0] s_awid,
  input  logic [7:0]      s_awlen,
  input  logic [1:0]      s_awburst,
  input  logic [2:0]      s_awsize,
  input  logic            s_wvalid,
  output logic            s_wready,
  input  logic [31:0]     s_wdata,
  input  logic [3:0]      s_wstrb,
  input  logic            s_wlast,
  output logic            s_bvalid,
  input  logic            s_bready,
  output logic [1:0]      s_bresp,
  output logic [TAGW-1:0] s_bid,
  output logic            m_arvalid,
  output logic [31:0]     m_araddr,
  output logic [TAGW-1:0] m_arid,
  output logic [7:0]      m_arlen,
  output logic [1:0]      m_arburst,
  output logic [2:0]      m_arsize,
  input  logic            m_rvalid,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic [TAGW-1:0] m_rid,
  output logic            m_rready,
  output logic            m_awvalid,
  output logic [31:0]     m_awaddr,
  output logic [TAGW-1:0] m_awid,
  output logic [7:0]      m_awlen,
  output logic [1:0]      m_awburst,
  output logic [2:0]      m_awsize,
  output logic            m_wvalid,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  input  logic            m_bvalid,
  input  logic [1:0]      m_bresp,
  input  logic [TAGW-1:0] m_bid,
  output logic            m_bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_ISSUE, WR_WAIT, WR_RESP
  } state_t;

  state_t state, state_nxt;
  logic [31:0]     addr, rdata_q, wdata_q;
  logic [TAGW-1:0] id;
  logic [7:0]      len, beat;
  logic [1:0]      burst, size, rresp_q, bresp_acc;
  logic [3:0]      wstrb_q;
  logic            prefer_wr, grant_rd, grant_wr, last_beat, timeout;

  function automatic logic [1:0] clamp_size(input logic [2:0] s);
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  // WRAP keeps the low bits inside an aligned (len+1)<<size window; illegal WRAP lengths fall back to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] bt,
                                            input logic [1:0] sz, input logic [7:0] ln);
    logic [31:0] step, mask;
    step = 32'd1 << sz;
    mask = (({24'd0, ln} + 32'd1) << sz) - 32'd1;
    if (bt == 2'b00)
      return a;
    else if (bt == 2'b10 && (ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15))
      return (a & ~mask) | ((a + step) & mask);
    else
      return a + step;
  endfunction

  assign last_beat = (beat == len);

`ifdef SOC_BURST_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        unused;
  assign unused  = ^{m_rid, m_bid};
  assign timeout = ((state == RD_WAIT && !m_rvalid) || (state == WR_WAIT && !m_bvalid)) &&
                   (wait_cnt == 16'(TIMEOUT_CYC - 1));
  always_ff @(posedge aclk) begin
    if (rst)
      wait_cnt <= '0;
    else if ((state == RD_WAIT || state == WR_WAIT) && !timeout && !m_rvalid && !m_bvalid)
      wait_cnt <= wait_cnt + 16'd1;
    else
      wait_cnt <= '0;
  end
`else
  logic unused;
  assign unused  = ^{m_rid, m_bid, 32'(TIMEOUT_CYC)};
  assign timeout = 1'b0;
`endif

  // Arbitration: one ready per cycle; ties alternate, write first after reset.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE && !rst) begin
      if (s_arvalid && s_awvalid) begin
        grant_wr = prefer_wr;
        grant_rd = !prefer_wr;
      end else begin
        grant_rd = s_arvalid;
        grant_wr = s_awvalid;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_wr) state_nxt = WR_DATA;
                else if (grant_rd) state_nxt = RD_ISSUE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (m_rvalid || timeout) state_nxt = RD_RESP;
      RD_RESP:  if (s_rready) state_nxt = last_beat ? IDLE : RD_ISSUE;
      WR_DATA:  if (s_wvalid) state_nxt = WR_ISSUE;
      WR_ISSUE: state_nxt = WR_WAIT;
      WR_WAIT:  if (m_bvalid || timeout) state_nxt = last_beat ? WR_RESP : WR_DATA;
      WR_RESP:  if (s_bready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_arready = grant_rd;
    s_awready = grant_wr;
    s_rvalid  = (state == RD_RESP);
    s_wready  = (state == WR_DATA);
    s_bvalid  = (state == WR_RESP);
    m_arvalid = (state == RD_ISSUE);
    m_awvalid = (state == WR_ISSUE);
    m_wvalid  = (state == WR_ISSUE);
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      addr <= '0; id <= '0; len <= '0; beat <= '0; burst <= '0; size <= '0;
      rdata_q <= '0; rresp_q <= '0; bresp_acc <= '0; wdata_q <= '0; wstrb_q <= '0;
      prefer_wr <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            addr <= s_awaddr; id <= s_awid; len <= s_awlen; burst <= s_awburst;
            size <= clamp_size(s_awsize); beat <= '0; bresp_acc <= '0;
          end else if (grant_rd) begin
            addr <= s_araddr; id <= s_arid; len <= s_arlen; burst <= s_arburst;
            size <= clamp_size(s_arsize); beat <= '0;
          end
          if (s_arvalid && s_awvalid) prefer_wr <= grant_rd;
        end
        RD_WAIT: begin
          if (m_rvalid) begin
            rdata_q <= m_rdata; rresp_q <= m_rresp;
          end else if (timeout) begin
            rdata_q <= 32'hDEAD_BEEF; rresp_q <= 2'b10;
          end
        end
        RD_RESP: if (s_rready && !last_beat) begin
          addr <= next_addr(addr, burst, size, len);
          beat <= beat + 8'd1;
        end
        // A wlast that disagrees with the beat count is flagged but does not end the burst.
        WR_DATA: if (s_wvalid) begin
          wdata_q <= s_wdata; wstrb_q <= s_wstrb;
          if (s_wlast != last_beat) bresp_acc <= bresp_acc | 2'b10;
        end
        WR_WAIT: begin
          if (m_bvalid)     bresp_acc <= bresp_acc | m_bresp;
          else if (timeout) bresp_acc <= bresp_acc | 2'b10;
          if ((m_bvalid || timeout) && !last_beat) begin
            addr <= next_addr(addr, burst, size, len);
            beat <= beat + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_rid     = id;
  assign s_rlast   = last_beat;
  assign s_bresp   = bresp_acc;
  assign s_bid     = id;
  assign m_araddr  = addr;
  assign m_arid    = id;
  assign m_arlen   = 8'd0;
  assign m_arburst = 2'b01;
  assign m_arsize  = 3'b010;
  assign m_rready  = 1'b1;
  assign m_awaddr  = addr;
  assign m_awid    = id;
  assign m_awlen   = 8'd0;
  assign m_awburst = 2'b01;
  assign m_awsize  = 3'b010;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = 1'b1;

endmodule

// File: tb/tb_soc_axi_burst_splitter.sv
// Directed bench for soc_axi_burst_splitter with a scoreboarded adapter model on the downstream side.
module tb_soc_axi_burst_splitter;
  localparam int TAGW = 16;

  logic aclk = 1'b0;
  logic rst;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [TAGW-1:0] s_arid, s_rid, s_awid, s_bid;
  logic [7:0] s_arlen, s_awlen;
  logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
  logic [2:0] s_arsize, s_awsize;
  logic [3:0] s_wstrb;
  logic m_arvalid, m_rvalid, m_rready, m_awvalid, m_wvalid, m_bvalid, m_bready;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [TAGW-1:0] m_arid, m_rid, m_awid, m_bid;
  logic [7:0] m_arlen, m_awlen;
  logic [1:0] m_arburst, m_awburst, m_rresp, m_bresp;
  logic [2:0] m_arsize, m_awsize;
  logic [3:0] m_wstrb;

  soc_axi_burst_splitter #(.TAGW(TAGW), .TIMEOUT_CYC(64)) dut (
    .aclk(aclk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arburst(m_arburst), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rid(m_rid), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awburst(m_awburst), .m_awsize(m_awsize),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wbeat_t;

  logic [31:0] exp_ar_q[$];
  rbeat_t      exp_r_q[$];
  wbeat_t      exp_w_q[$];
  logic [31:0] plan_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        suppress_rd = 1'b0;
  logic [1:0]  b_inj = 2'b00;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return 32'h1234_5670 + a;
  endfunction

  function automatic logic [3:0] strb_fn(input int k);
    return 4'hF ^ 4'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Adapter model: checks each issued access against the scoreboard and answers one cycle later.
  initial begin : adapter
    logic        rd_pend, wr_pend;
    logic [31:0] rd_a;
    wbeat_t      w;
    rd_pend = 1'b0; wr_pend = 1'b0; rd_a = '0;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rid = '0;
    m_bvalid = 1'b0; m_bresp = '0; m_bid = '0;
    forever begin
      @(negedge aclk);
      m_rvalid = 1'b0;
      m_bvalid = 1'b0;
      if (rd_pend) begin
        m_rvalid = 1'b1; m_rdata = data_fn(rd_a); m_rresp = 2'b00; rd_pend = 1'b0;
      end
      if (wr_pend) begin
        m_bvalid = 1'b1; m_bresp = b_inj; wr_pend = 1'b0;
      end
      if (m_arvalid) begin
        chk("m_ar_const", {m_arlen, m_arburst, m_arsize, m_rready}, {8'd0, 2'b01, 3'b010, 1'b1});
        if (exp_ar_q.size() == 0) chk("m_ar_extra", m_arvalid, 1'b0);
        else chk("m_araddr", m_araddr, exp_ar_q.pop_front());
        rd_a = m_araddr;
        rd_pend = !suppress_rd;
      end
      if (m_awvalid) begin
        chk("m_aw_const", {m_wvalid, m_awlen, m_awburst, m_awsize, m_bready},
            {1'b1, 8'd0, 2'b01, 3'b010, 1'b1});
        if (exp_w_q.size() == 0) chk("m_aw_extra", m_awvalid, 1'b0);
        else begin
          w = exp_w_q.pop_front();
          chk("m_awaddr", m_awaddr, w.addr);
          chk("m_wdata", {m_wdata, m_wstrb}, {w.data, w.strb});
        end
        wr_pend = 1'b1;
      end
    end
  end

  task automatic prep_read(input int len);
    for (int k = 0; k <= len; k++) begin
      exp_ar_q.push_back(plan_q[k]);
      exp_r_q.push_back('{data_fn(plan_q[k]), 2'b00, (k == len)});
    end
  endtask

  task automatic prep_write(input int len, input logic [31:0] base);
    for (int k = 0; k <= len; k++)
      exp_w_q.push_back('{plan_q[k], base + 32'(k), strb_fn(k)});
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [TAGW-1:0] i, input logic [7:0] l,
                         input logic [1:0] b, input logic [2:0] s);
    int n = 0;
    s_arvalid = 1'b1; s_araddr = a; s_arid = i; s_arlen = l; s_arburst = b; s_arsize = s;
    #1;
    while (!s_arready && n < 200) begin @(negedge aclk); #1; n++; end
    chk("ar_handshake", s_arready, 1'b1);
    @(negedge aclk);
    s_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [TAGW-1:0] i, input logic [7:0] l,
                         input logic [1:0] b, input logic [2:0] s);
    int n = 0;
    s_awvalid = 1'b1; s_awaddr = a; s_awid = i; s_awlen = l; s_awburst = b; s_awsize = s;
    #1;
    while (!s_awready && n < 200) begin @(negedge aclk); #1; n++; end
    chk("aw_handshake", s_awready, 1'b1);
    @(negedge aclk);
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic last);
    int n = 0;
    s_wvalid = 1'b1; s_wdata = d; s_wstrb = st; s_wlast = last;
    #1;
    while (!s_wready && n < 200) begin @(negedge aclk); #1; n++; end
    chk("w_handshake", s_wready, 1'b1);
    @(negedge aclk);
    s_wvalid = 1'b0;
  endtask

  task automatic recv_r(input logic [TAGW-1:0] i, input int hold);
    int n = 0;
    rbeat_t e;
    #1;
    while (!s_rvalid && n < 300) begin @(negedge aclk); #1; n++; end
    chk("s_rvalid", s_rvalid, 1'b1);
    repeat (hold) @(negedge aclk);
    #1;
    if (exp_r_q.size() == 0) chk("r_extra", s_rvalid, 1'b0);
    else begin
      e = exp_r_q.pop_front();
      chk("s_rvalid_held", s_rvalid, 1'b1);
      chk("s_rdata", s_rdata, e.data);
      chk("s_rresp_rlast", {s_rresp, s_rlast}, {e.resp, e.last});
      chk("s_rid", s_rid, i);
    end
    s_rready = 1'b1;
    @(negedge aclk);
    s_rready = 1'b0;
  endtask

  task automatic recv_b(input logic [1:0] resp, input logic [TAGW-1:0] i);
    int n = 0;
    #1;
    while (!s_bvalid && n < 300) begin @(negedge aclk); #1; n++; end
    chk("s_bvalid", s_bvalid, 1'b1);
    chk("s_bresp", s_bresp, resp);
    chk("s_bid", s_bid, i);
    s_bready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [TAGW-1:0] i, input int len,
                         input logic [1:0] b, input logic [2:0] s, input int hold);
    prep_read(len);
    send_ar(a, i, 8'(len), b, s);
    for (int k = 0; k <= len; k++) recv_r(i, hold);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [TAGW-1:0] i, input int len,
                          input logic [1:0] b, input logic [2:0] s, input logic [31:0] base,
                          input int last_at, input logic [1:0] resp);
    prep_write(len, base);
    send_aw(a, i, 8'(len), b, s);
    for (int k = 0; k <= len; k++) send_w(base + 32'(k), strb_fn(k), (k == last_at));
    recv_b(resp, i);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arburst = 0; s_arsize = 0;
    s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awburst = 0; s_awsize = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_rready = 0; s_bready = 0;
    repeat (3) @(negedge aclk);
    #1;
    chk("reset_ctrl", {s_arready, s_awready, s_wready, s_rvalid, s_bvalid, m_arvalid, m_awvalid,
                       m_wvalid, s_rresp, s_bresp}, '0);
    chk("reset_mdata", {m_araddr, m_awaddr, m_wdata, m_wstrb}, '0);
    @(negedge aclk);
    rst = 1'b0;

    plan_q = '{32'h8};
    do_read(32'h8, 16'h0A5A, 0, 2'b01, 3'd2, 0);

    plan_q = '{32'h10, 32'h14, 32'h18, 32'h1C};
    do_read(32'h10, 16'h0011, 3, 2'b01, 3'd2, 5);

    plan_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
    do_write(32'h38, 16'h0022, 3, 2'b10, 3'd2, 32'hCAFE_0000, 3, 2'b00);

    // First tie after reset: write first, read waits.
    plan_q = '{32'h200}; prep_read(0);
    plan_q = '{32'h300}; prep_write(0, 32'hA000_0000);
    s_arvalid = 1; s_araddr = 32'h200; s_arid = 16'h0001; s_arlen = 0; s_arburst = 2'b01; s_arsize = 3'd2;
    s_awvalid = 1; s_awaddr = 32'h300; s_awid = 16'h0002; s_awlen = 0; s_awburst = 2'b01; s_awsize = 3'd2;
    #1;
    chk("tie1_grant_aw_ar", {s_awready, s_arready}, 2'b10);
    @(negedge aclk);
    s_awvalid = 0;
    send_w(32'hA000_0000, strb_fn(0), 1'b1);
    recv_b(2'b00, 16'h0002);
    n = 0; #1;
    while (!s_arready && n < 50) begin @(negedge aclk); #1; n++; end
    chk("tie1_read_after", s_arready, 1'b1);
    @(negedge aclk);
    s_arvalid = 0;
    recv_r(16'h0001, 0);

    // Second tie: read first.
    plan_q = '{32'h204}; prep_read(0);
    plan_q = '{32'h304}; prep_write(0, 32'hB000_0000);
    s_arvalid = 1; s_araddr = 32'h204; s_arid = 16'h0003;
    s_awvalid = 1; s_awaddr = 32'h304; s_awid = 16'h0004;
    #1;
    chk("tie2_grant_aw_ar", {s_awready, s_arready}, 2'b01);
    @(negedge aclk);
    s_arvalid = 0;
    recv_r(16'h0003, 2);
    n = 0; #1;
    while (!s_awready && n < 50) begin @(negedge aclk); #1; n++; end
    chk("tie2_write_after", s_awready, 1'b1);
    @(negedge aclk);
    s_awvalid = 0;
    send_w(32'hB000_0000, strb_fn(0), 1'b1);
    recv_b(2'b00, 16'h0004);

    plan_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    do_write(32'h100, 16'h0033, 3, 2'b01, 3'd2, 32'h5500_0000, 1, 2'b10);

    b_inj = 2'b01;
    plan_q = '{32'h120};
    do_write(32'h120, 16'h0034, 0, 2'b01, 3'd2, 32'h7700_0000, 0, 2'b01);
    b_inj = 2'b00;

    plan_q = '{32'h40, 32'h40};
    do_read(32'h40, 16'h0044, 1, 2'b00, 3'd2, 0);
    plan_q = '{32'hFFFF_FFFC, 32'h0};
    do_read(32'hFFFF_FFFC, 16'h0055, 1, 2'b01, 3'd2, 1);
    plan_q = '{32'h24, 32'h28, 32'h2C};
    do_read(32'h24, 16'h0066, 2, 2'b10, 3'd2, 0);
    plan_q = '{32'h44, 32'h40};
    do_read(32'h44, 16'h0077, 1, 2'b10, 3'd5, 0);

    // Reset in the middle of a read burst: no response, back to idle.
    plan_q = '{32'h500, 32'h504}; prep_read(1);
    send_ar(32'h500, 16'h0088, 8'd1, 2'b01, 3'd2);
    n = 0; #1;
    while (!s_rvalid && n < 50) begin @(negedge aclk); #1; n++; end
    chk("midrst_beat0", s_rvalid, 1'b1);
    @(negedge aclk);
    rst = 1'b1;
    @(negedge aclk);
    #1;
    chk("midrst_quiet", {s_rvalid, s_bvalid, m_arvalid, m_awvalid, s_wready}, 5'b0);
    rst = 1'b0;
    exp_ar_q.delete();
    exp_r_q.delete();
    @(negedge aclk);
    plan_q = '{32'h600};
    do_read(32'h600, 16'h0099, 0, 2'b01, 3'd2, 0);

`ifdef SOC_BURST_TIMEOUT_EN
    suppress_rd = 1'b1;
    exp_ar_q.push_back(32'h700);
    exp_r_q.push_back('{32'hDEAD_BEEF, 2'b10, 1'b1});
    send_ar(32'h700, 16'h00AA, 8'd0, 2'b01, 3'd2);
    recv_r(16'h00AA, 0);
    suppress_rd = 1'b0;
`endif

    repeat (3) @(negedge aclk);
    chk("scoreboard_empty", {32'(exp_ar_q.size()), 32'(exp_w_q.size() + exp_r_q.size())}, 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
